// File: rtl/mmio_bridge_pkg.sv
// Shared types and defaults for the multi-slave MMIO bridge.
package klp32_mmio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [31:0]  MMIO_BASE_DEFAULT = 32'h1000_0000;
  localparam int unsigned  SPAN_LOG2_DEFAULT = 24;
  localparam int unsigned  ERR_CNT_W         = 8;

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational MMIO window decode: byte address -> {hit, slave index, region offset}.
module mmio_addr_decode
  import klp32_mmio_pkg::*;
#(
  parameter int unsigned       NUM_SLAVES = 4,
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] MMIO_BASE  = ADDR_W'(MMIO_BASE_DEFAULT),
  parameter int unsigned       SPAN_LOG2  = SPAN_LOG2_DEFAULT,
  localparam int unsigned      IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] offset
);

  // Window bounds carry one extra bit so a window ending at the top of the
  // address space does not wrap to zero.
  localparam logic [ADDR_W:0]   WIN_LO    = {1'b0, MMIO_BASE};
  localparam logic [ADDR_W:0]   WIN_HI    = WIN_LO + ((ADDR_W+1)'(NUM_SLAVES) << SPAN_LOG2);
  localparam logic [ADDR_W-1:0] SPAN_MASK = (ADDR_W'(1) << SPAN_LOG2) - ADDR_W'(1);

  logic [ADDR_W-1:0] rel;

  always_comb begin
    rel    = addr - MMIO_BASE;
    hit    = ({1'b0, addr} >= WIN_LO) && ({1'b0, addr} < WIN_HI);
    idx    = IDX_W'(rel >> SPAN_LOG2);
    offset = rel & SPAN_MASK;
  end

endmodule

// File: rtl/mmio_bridge.sv
// Memory-stage to NUM_SLAVES peripheral bridge with wait states, timeout and error counting.
module mmio_bridge
  import klp32_mmio_pkg::*;
#(
  parameter int unsigned       NUM_SLAVES     = 4,
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter logic [ADDR_W-1:0] MMIO_BASE      = ADDR_W'(MMIO_BASE_DEFAULT),
  parameter int unsigned       SPAN_LOG2      = SPAN_LOG2_DEFAULT,
  parameter int unsigned       TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_wr,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [DATA_W/8-1:0]          req_be,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [ERR_CNT_W-1:0]         err_count,
  output logic [NUM_SLAVES-1:0]        s_cs,
  output logic                         s_wr,
  output logic                         s_rd,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_be,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ready
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state, state_n;
  logic              dec_hit;
  logic [IDX_W-1:0]  dec_idx, idx_q;
  logic [ADDR_W-1:0] dec_offset;
  logic              wr_q;
  logic [TMR_W-1:0]  timer;
  logic              sel_ready, timeout;
  logic [DATA_W-1:0] sel_rdata;

  mmio_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .MMIO_BASE  (MMIO_BASE),
    .SPAN_LOG2  (SPAN_LOG2)
  ) u_decode (
    .addr   (req_addr),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .offset (dec_offset)
  );

  always_comb begin
    sel_ready = s_ready[idx_q];
    sel_rdata = s_rdata[int'(idx_q)*DATA_W +: DATA_W];
    timeout   = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (req_valid) state_n = dec_hit ? ACCESS : RESP;
      ACCESS:  if (sel_ready || timeout) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Strobes decode straight from registered state and latched fields.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    s_wr      = (state == ACCESS) &&  wr_q;
    s_rd      = (state == ACCESS) && !wr_q;
    s_cs      = '0;
    if (state == ACCESS) s_cs[idx_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q      <= 1'b0;
      idx_q     <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_be      <= '0;
      timer     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_count <= '0;
    end else begin
      timer <= (state == ACCESS) ? timer + 1'b1 : '0;
      if (state == IDLE && req_valid) begin
        wr_q    <= req_wr;
        idx_q   <= dec_idx;
        s_addr  <= dec_offset;
        s_wdata <= req_wdata;
        s_be    <= req_be;
        if (!dec_hit) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
      // Ready is tested first so it wins over a simultaneous timeout.
      if (state == ACCESS) begin
        if (sel_ready) begin
          rsp_err   <= 1'b0;
          rsp_rdata <= wr_q ? '0 : sel_rdata;
        end else if (timeout) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
      if (state == RESP && rsp_err && err_count != '1)
        err_count <= err_count + 1'b1;
    end
  end

endmodule
